// File: rtl/serial_rx.sv
// 8N1 UART receiver: 2-FF synchronised line, mid-bit sampling, valid/ack holding register
// with sticky overrun and a one-cycle framing-error pulse.
module serial_rx #(
    parameter int unsigned inputFrequency = 25000000,
    parameter int unsigned baudRate       = 115200,
    parameter int unsigned baudGenWidth   = 16,
    parameter int unsigned clocksPerBit   = inputFrequency / baudRate,
    parameter int unsigned halfBit        = clocksPerBit / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun,
    output logic       frameError,
    output logic       busy
);

    localparam logic [baudGenWidth-1:0] LastCount = baudGenWidth'(clocksPerBit - 1);
    localparam logic [baudGenWidth-1:0] HalfCount = baudGenWidth'(halfBit);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                  state_q, state_d;
    logic [baudGenWidth-1:0] cnt_q, cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [7:0]              shift_q, shift_d;
    logic                    commit_q, commit_d;
    logic                    frame_err_q, frame_err_d;
    logic                    rx_meta_q, rx_s_q;
    logic [7:0]              data_q;
    logic                    valid_q, overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfCount) begin
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == LastCount) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    // Restart bit timing for each data bit; the state itself does not change.
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop: begin
                if (cnt_q == LastCount) begin
                    if (rx_s_q) begin
                        state_d  = StIdle;
                        commit_d = 1'b1;
                    end else begin
                        state_d     = StBreak;
                        frame_err_d = 1'b1;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A commit takes priority over a same-cycle ack; overrun only when nobody consumed the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (commit_q) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            if (valid_q && !ack) overrun_q <= 1'b1;
            else if (valid_q && ack) overrun_q <= 1'b0;
        end else if (ack && valid_q) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;
    assign frameError = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: table of frames at nominal and +/-2% bit times, plus
// hand-written sequences for back-to-back, glitch, break, overrun and mid-frame reset.
module tb_serial_rx;

    localparam int unsigned Cpb = 217;

    logic       clk, rst, rx, ack;
    logic [7:0] data;
    logic       valid, overrun, frameError, busy;

    int n_vec  = 0;
    int n_fail = 0;
    int fe_cnt = 0;

    serial_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .ack        (ack),
        .data       (data),
        .valid      (valid),
        .overrun    (overrun),
        .frameError (frameError),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frameError === 1'b1) fe_cnt++;

    typedef struct {
        logic [7:0]  tx;
        int unsigned cpb;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start bit plus eight data bits; leaves rx high at the start of the stop bit.
    task automatic send_bits(input logic [7:0] b, input int unsigned cpb);
        rx = 1'b0;
        repeat (cpb) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) tick();
        end
        rx = 1'b1;
    endtask

    task automatic wait_valid(output bit ok, input int limit);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_busy_fall(output bit ok, input int limit);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        bit         ok;
        bit         seen;
        int         fe0;
        logic [7:0] got[3];

        vecs[0] = '{tx: 8'hA5, cpb: 217, exp: 8'hA5};
        vecs[1] = '{tx: 8'h01, cpb: 217, exp: 8'h01};
        vecs[2] = '{tx: 8'h80, cpb: 213, exp: 8'h80};
        vecs[3] = '{tx: 8'h7E, cpb: 221, exp: 8'h7E};

        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_data", data, 8'h00);
        rst = 1'b0;
        repeat (1000) tick();
        check("idle_valid", valid, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_error_count", fe_cnt, 0);
        check("idle_data", data, 8'h00);

        // 0xA5 with commit timing and a delayed ack.
        send_bits(8'hA5, Cpb);
        wait_busy_fall(ok, 2 * Cpb);
        check("a5_stop_sample_seen", ok, 1);
        check("a5_valid_at_stop_sample", valid, 0);
        tick();
        check("a5_valid_next_cycle", valid, 1);
        check("a5_data", data, 8'hA5);
        repeat (5) tick();
        check("a5_valid_held", valid, 1);
        pulse_ack();
        check("a5_valid_after_ack", valid, 0);
        check("a5_data_held_after_ack", data, 8'hA5);
        check("a5_overrun", overrun, 0);
        repeat (Cpb) tick();

        foreach (vecs[v]) begin
            fe0 = fe_cnt;
            send_bits(vecs[v].tx, vecs[v].cpb);
            wait_valid(ok, 2 * vecs[v].cpb);
            check($sformatf("vec%0d_valid_timeout", v), ok, 1);
            check($sformatf("vec%0d_data", v), data, vecs[v].exp);
            check($sformatf("vec%0d_overrun", v), overrun, 0);
            pulse_ack();
            check($sformatf("vec%0d_valid_after_ack", v), valid, 0);
            repeat (vecs[v].cpb) tick();
            check($sformatf("vec%0d_frame_errors", v), fe_cnt - fe0, 0);
        end

        // Back-to-back single-stop frames with a concurrent acker.
        fe0 = fe_cnt;
        fork
            begin
                send_bits(8'h00, Cpb);
                repeat (Cpb) tick();
                send_bits(8'hFF, Cpb);
                repeat (Cpb) tick();
                send_bits(8'h3C, Cpb);
                repeat (Cpb) tick();
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_valid(ok, 12 * Cpb);
                    check($sformatf("b2b%0d_valid_timeout", k), ok, 1);
                    got[k] = data;
                    pulse_ack();
                end
            end
        join
        check("b2b0_data", got[0], 8'h00);
        check("b2b1_data", got[1], 8'hFF);
        check("b2b2_data", got[2], 8'h3C);
        check("b2b_frame_errors", fe_cnt - fe0, 0);
        check("b2b_overrun", overrun, 0);
        repeat (Cpb) tick();

        // 50-cycle low glitch is rejected at the start-bit mid-sample.
        fe0  = fe_cnt;
        seen = 1'b0;
        rx   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy === 1'b1) seen = 1'b1;
        end
        rx = 1'b1;
        repeat (300) tick();
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_after", busy, 0);
        check("glitch_valid", valid, 0);
        check("glitch_frame_errors", fe_cnt - fe0, 0);

        // Bad stop bit followed by a long break: one pulse, busy until the line returns.
        fe0  = fe_cnt;
        seen = 1'b0;
        send_bits(8'h55, Cpb);
        rx = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (valid === 1'b1) seen = 1'b1;
        end
        check("break_frame_errors", fe_cnt - fe0, 1);
        check("break_valid_seen", seen, 0);
        check("break_busy", busy, 1);
        rx = 1'b1;
        repeat (5) tick();
        check("break_busy_released", busy, 0);
        repeat (Cpb) tick();

        // Overrun: two frames without ack.
        send_bits(8'h11, Cpb);
        repeat (Cpb) tick();
        check("ovr_first_data", data, 8'h11);
        check("ovr_first_overrun", overrun, 0);
        send_bits(8'h22, Cpb);
        repeat (Cpb) tick();
        check("ovr_data", data, 8'h22);
        check("ovr_valid", valid, 1);
        check("ovr_overrun", overrun, 1);
        pulse_ack();
        check("ovr_valid_after_ack", valid, 0);
        check("ovr_overrun_after_ack", overrun, 0);

        // Reset during bit 4 of a further frame.
        rx = 1'b0;
        repeat (5 * Cpb + 100) tick();
        check("midreset_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        check("midreset_data", data, 8'h00);
        check("midreset_valid", valid, 0);
        check("midreset_overrun", overrun, 0);
        check("midreset_frame_error", frameError, 0);
        check("midreset_busy", busy, 0);
        rx  = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12 * Cpb) tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
